cci_mpf_svc_vtp_miss_tracker: RTL and testbench
===============================================

# cci_mpf_svc_vtp_miss_tracker

Tracks outstanding TLB misses between the VTP TLB and the hardware page table walker. It accepts miss notifications tagged with a service request tag and merges misses to the same 4KB VA page. It issues one walk request per unique page, installs the returned translation in the TLB, and emits one service lookup response per merged tag.

## Interface
- N_ENTRIES, 4, outstanding unique-page walks (2..8)
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- missEn  in  1  new TLB miss
- missVA  in  t_tlb_4kb_va_page_idx  missed page
- missTag  in  t_cci_mpf_shim_vtp_req_tag  service tag of the missing request
- missRdy  out  1  miss can be accepted this cycle
- walkReqEn  out  1  walk request valid
- walkReqVA  out  t_tlb_4kb_va_page_idx
- walkReqTag  out  t_cci_mpf_shim_vtp_req_tag  first tag of the entry
- walkReqMeta  out  t_cci_mpf_shim_vtp_pt_walk_meta  entry index, zero-extended
- walkReqRdy  in  1  walker accepts
- walkRspEn, walkRspVA, walkRspPA, walkRspMeta, walkRspTag, walkRspIsBigPage, walkRspNotPresent  in  pt_walk_if response fields
- fillEn, fillVA, fillPA, fillBigPage  out  TLB fill port
- svcRspValid  out  1; svcRsp  out  t_cci_mpf_shim_vtp_lookup_rsp
- errNotPresent  out  1  sticky; errVA  out  t_tlb_4kb_va_page_idx  first faulting VA
- numBusy  out  $clog2(N_ENTRIES+1)  non-FREE entries

## Operation
- Each entry holds: state, VA, 16-bit tagMask (one bit per tag), PA, isBigPage.
- States: FREE -> ISSUE (alloc) -> WALK (walkReqEn && walkReqRdy) -> RESP (walkRspEn, meta = entry) -> FREE (tagMask drained).
- Miss acceptance (missEn && missRdy):
  - If missVA equals the VA of an entry in ISSUE or WALK, set tagMask[missTag] in that entry. No new walk.
  - Otherwise allocate the lowest-index FREE entry with tagMask = one-hot(missTag).
  - Misses never merge into RESP entries.
- missRdy = at least one FREE entry. This is conservative: merges are also blocked when the table is full.
- Walk issue: the lowest-index ISSUE entry drives walkReq*. It stays registered and stable until walkReqRdy. Only one request is presented at a time.
- Walk response:
  - Entry = walkRspMeta[$clog2(N_ENTRIES)-1:0]. Store PA and IsBigPage.
  - Normal case: next cycle, pulse fillEn with the entry VA, walkRspPA, and walkRspIsBigPage.
  - If walkRspNotPresent: no fill, no svcRsp. Entry -> FREE. Set errNotPresent. Capture errVA only if the error is not already set.
- Drain: the lowest-index RESP entry emits one svcRsp per cycle, lowest set tag bit first: {pagePA, tag, isBigPage}. It clears that bit. When the mask reaches zero, the entry -> FREE in the same cycle.

## Timing
- Reset: all entries FREE, all masks 0. Every output is 0 except missRdy, which is 1.
- Alloc visible in walkReqEn the cycle after acceptance.
- Latencies from walkRspEn at cycle T:
  - fillEn at T+1.
  - First svcRsp no earlier than T+2, or later if another RESP entry is draining.
- Responses from different entries serialize by index priority. No ordering is guaranteed across entries.
- Simultaneous miss-merge and walkRsp to the same entry: the new tag bit is included in the drain.
- Simultaneous alloc and free in one cycle:
  - Freed entry is not reusable until the next cycle.
  - missRdy uses registered state.
- A miss with a tag already set in any mask is illegal. The simulation assertion fires.
- A walkRsp naming a non-WALK entry is illegal. The simulation assertion fires.
- Reset asserted mid-operation: all state is discarded. The walker's in-flight responses after reset are the integrator's responsibility.

## Structure
- Place the entry-state enum and t_vtp_miss_entry struct in the shared VTP header alongside the pt_walk typedefs.
- Use one sub-module, cci_mpf_prim_arb_lowest, a find-first-set priority encoder. It is instantiated three times: free-entry select, issue select, and drain/tag select.

## Test plan
- Single miss VA=0x100, tag 3:
  - walkReq VA=0x100, meta 0.
  - Walk response PA=0x2000, 4KB.
  - fillEn with VA 0x100, PA 0x2000 one cycle after the response.
  - svcRsp {0x2000, 3, 0}.
- Merge: tags 1, 5, 9 all miss VA=0x40 before the walk response:
  - One walkReq only.
  - Three svcRsps in consecutive cycles, tags 1, 5, 9.
- Full table: N_ENTRIES unique misses.
  - missRdy drops.
  - It returns high the cycle after the first entry drains.
- Out-of-order walk responses (meta 2 before meta 0): each fill and response carries the correct PA for its VA.
- NotPresent on VA=0x7 while errNotPresent is clear:
  - No fill and no svcRsp.
  - errNotPresent=1, errVA=0x7.
  - Entry freed.
- Reset mid-drain: no svcRspValid next cycle, numBusy=0, missRdy=1.

Source files
------------

// File: rtl/cci_mpf_svc_vtp_miss_tracker_pkg.sv
// Shared VTP types: page indices, service tags, page-walk metadata and the
// miss-tracker entry record.
package cci_mpf_svc_vtp_miss_tracker_pkg;

    localparam int N_TAGS = 16;
    localparam int TAG_W  = 4;
    localparam int META_W = 8;

    typedef logic [35:0]       t_tlb_4kb_va_page_idx;
    typedef logic [27:0]       t_tlb_4kb_pa_page_idx;
    typedef logic [TAG_W-1:0]  t_cci_mpf_shim_vtp_req_tag;
    typedef logic [META_W-1:0] t_cci_mpf_shim_vtp_pt_walk_meta;

    typedef struct packed {
        t_tlb_4kb_pa_page_idx      pagePA;
        t_cci_mpf_shim_vtp_req_tag tag;
        logic                      isBigPage;
    } t_cci_mpf_shim_vtp_lookup_rsp;

    typedef enum logic [1:0] {
        VTP_MISS_FREE,
        VTP_MISS_ISSUE,
        VTP_MISS_WALK,
        VTP_MISS_RESP
    } t_vtp_miss_state;

    typedef struct packed {
        t_vtp_miss_state           state;
        t_tlb_4kb_va_page_idx      va;
        t_cci_mpf_shim_vtp_req_tag firstTag;
        logic [N_TAGS-1:0]         tagMask;
        t_tlb_4kb_pa_page_idx      pa;
        logic                      isBigPage;
    } t_vtp_miss_entry;

endpackage

// File: rtl/cci_mpf_prim_arb_lowest.sv
// Find-first-set priority encoder: reports the lowest set request bit.
module cci_mpf_prim_arb_lowest #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IDX_W = $clog2(N);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i] && !found) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/cci_mpf_svc_vtp_miss_tracker.sv
// Tracks outstanding VTP TLB misses: merges same-page misses, issues one page
// walk per unique page, fills the TLB and drains one lookup response per tag.
module cci_mpf_svc_vtp_miss_tracker
    import cci_mpf_svc_vtp_miss_tracker_pkg::*;
#(
    parameter int N_ENTRIES = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           missEn,
    input  t_tlb_4kb_va_page_idx           missVA,
    input  t_cci_mpf_shim_vtp_req_tag      missTag,
    output logic                           missRdy,
    output logic                           walkReqEn,
    output t_tlb_4kb_va_page_idx           walkReqVA,
    output t_cci_mpf_shim_vtp_req_tag      walkReqTag,
    output t_cci_mpf_shim_vtp_pt_walk_meta walkReqMeta,
    input  logic                           walkReqRdy,
    input  logic                           walkRspEn,
    input  t_tlb_4kb_va_page_idx           walkRspVA,
    input  t_tlb_4kb_pa_page_idx           walkRspPA,
    input  t_cci_mpf_shim_vtp_pt_walk_meta walkRspMeta,
    input  t_cci_mpf_shim_vtp_req_tag      walkRspTag,
    input  logic                           walkRspIsBigPage,
    input  logic                           walkRspNotPresent,
    output logic                           fillEn,
    output t_tlb_4kb_va_page_idx           fillVA,
    output t_tlb_4kb_pa_page_idx           fillPA,
    output logic                           fillBigPage,
    output logic                           svcRspValid,
    output t_cci_mpf_shim_vtp_lookup_rsp   svcRsp,
    output logic                           errNotPresent,
    output t_tlb_4kb_va_page_idx           errVA,
    output logic [$clog2(N_ENTRIES+1)-1:0] numBusy
);

    localparam int IDX_W       = $clog2(N_ENTRIES);
    localparam int CNT_W       = $clog2(N_ENTRIES + 1);
    localparam int DRAIN_W     = N_ENTRIES * N_TAGS;
    localparam int DRAIN_IDX_W = $clog2(DRAIN_W);

    t_vtp_miss_entry entry_q [N_ENTRIES];
    t_vtp_miss_entry entry_d [N_ENTRIES];

    logic                         walk_req_en_q, walk_req_en_d;
    t_tlb_4kb_va_page_idx         walk_req_va_q, walk_req_va_d;
    t_cci_mpf_shim_vtp_req_tag    walk_req_tag_q, walk_req_tag_d;
    logic [IDX_W-1:0]             walk_req_idx_q, walk_req_idx_d;
    logic                         fill_en_q, fill_en_d;
    t_tlb_4kb_va_page_idx         fill_va_q, fill_va_d;
    t_tlb_4kb_pa_page_idx         fill_pa_q, fill_pa_d;
    logic                         fill_big_q, fill_big_d;
    logic                         svc_valid_q, svc_valid_d;
    t_cci_mpf_shim_vtp_lookup_rsp svc_rsp_q, svc_rsp_d;
    logic                         err_q, err_d;
    t_tlb_4kb_va_page_idx         err_va_q, err_va_d;

    logic [N_ENTRIES-1:0]   free_vec, issue_vec;
    logic [DRAIN_W-1:0]     drain_vec;
    logic                   free_found, issue_found, drain_found;
    logic [IDX_W-1:0]       free_idx, issue_idx, drain_ent, rsp_idx, hit_idx;
    logic [DRAIN_IDX_W-1:0] drain_idx;
    t_cci_mpf_shim_vtp_req_tag drain_tag;
    logic                   hit, tag_dup, miss_acc, walk_acc;
    logic                   unused_rsp;

    assign unused_rsp = ^{walkRspVA, walkRspTag, walkRspMeta};
    assign rsp_idx    = walkRspMeta[IDX_W-1:0];
    assign miss_acc   = missEn && missRdy;
    assign walk_acc   = walk_req_en_q && walkReqRdy;
    // Drain arbitration runs over every (entry, tag) bit at once.
    assign drain_ent  = drain_idx[DRAIN_IDX_W-1:TAG_W];
    assign drain_tag  = drain_idx[TAG_W-1:0];

    always_comb begin
        free_vec  = '0;
        drain_vec = '0;
        for (int unsigned i = 0; i < N_ENTRIES; i++) begin
            free_vec[i] = (entry_q[i].state == VTP_MISS_FREE);
            if (entry_q[i].state == VTP_MISS_RESP)
                drain_vec[i*N_TAGS +: N_TAGS] = entry_q[i].tagMask;
        end
    end

    cci_mpf_prim_arb_lowest #(.N(N_ENTRIES)) free_arb (
        .req(free_vec), .found(free_found), .idx(free_idx));
    cci_mpf_prim_arb_lowest #(.N(N_ENTRIES)) issue_arb (
        .req(issue_vec), .found(issue_found), .idx(issue_idx));
    cci_mpf_prim_arb_lowest #(.N(DRAIN_W)) drain_arb (
        .req(drain_vec), .found(drain_found), .idx(drain_idx));

    // An entry faulting this cycle is not a merge target; the miss re-walks.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        tag_dup = 1'b0;
        for (int unsigned i = 0; i < N_ENTRIES; i++) begin
            if (((entry_q[i].state == VTP_MISS_ISSUE) || (entry_q[i].state == VTP_MISS_WALK)) &&
                (entry_q[i].va == missVA) && !hit &&
                !(walkRspEn && walkRspNotPresent && (rsp_idx == IDX_W'(i)))) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (entry_q[i].tagMask[missTag])
                tag_dup = 1'b1;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N_ENTRIES; i++)
            entry_d[i] = entry_q[i];
        fill_en_d   = walkRspEn && !walkRspNotPresent;
        fill_va_d   = entry_q[rsp_idx].va;
        fill_pa_d   = walkRspPA;
        fill_big_d  = walkRspIsBigPage;
        err_d       = err_q;
        err_va_d    = err_va_q;
        svc_valid_d = drain_found;
        svc_rsp_d   = '{pagePA: entry_q[drain_ent].pa, tag: drain_tag,
                        isBigPage: entry_q[drain_ent].isBigPage};

        if (walk_acc)
            entry_d[walk_req_idx_q].state = VTP_MISS_WALK;

        if (walkRspEn) begin
            if (walkRspNotPresent) begin
                entry_d[rsp_idx].state   = VTP_MISS_FREE;
                entry_d[rsp_idx].tagMask = '0;
                err_d = 1'b1;
                if (!err_q)
                    err_va_d = entry_q[rsp_idx].va;
            end else begin
                entry_d[rsp_idx].state     = VTP_MISS_RESP;
                entry_d[rsp_idx].pa        = walkRspPA;
                entry_d[rsp_idx].isBigPage = walkRspIsBigPage;
            end
        end

        if (drain_found) begin
            entry_d[drain_ent].tagMask[drain_tag] = 1'b0;
            if (entry_d[drain_ent].tagMask == '0)
                entry_d[drain_ent].state = VTP_MISS_FREE;
        end

        if (miss_acc) begin
            if (hit)
                entry_d[hit_idx].tagMask[missTag] = 1'b1;
            else
                entry_d[free_idx] = '{state: VTP_MISS_ISSUE, va: missVA, firstTag: missTag,
                                      tagMask: 16'b1 << missTag, pa: '0, isBigPage: 1'b0};
        end
    end

    // Issue selection looks at next state so a new alloc reaches walkReq at once.
    always_comb begin
        for (int unsigned i = 0; i < N_ENTRIES; i++)
            issue_vec[i] = (entry_d[i].state == VTP_MISS_ISSUE);
    end

    always_comb begin
        walk_req_en_d  = walk_req_en_q;
        walk_req_va_d  = walk_req_va_q;
        walk_req_tag_d = walk_req_tag_q;
        walk_req_idx_d = walk_req_idx_q;
        if (!walk_req_en_q || walkReqRdy) begin
            walk_req_en_d  = issue_found;
            walk_req_va_d  = entry_d[issue_idx].va;
            walk_req_tag_d = entry_d[issue_idx].firstTag;
            walk_req_idx_d = issue_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < N_ENTRIES; i++)
                entry_q[i] <= '{state: VTP_MISS_FREE, va: '0, firstTag: '0,
                                tagMask: '0, pa: '0, isBigPage: 1'b0};
            walk_req_en_q  <= 1'b0;
            walk_req_va_q  <= '0;
            walk_req_tag_q <= '0;
            walk_req_idx_q <= '0;
            fill_en_q      <= 1'b0;
            fill_va_q      <= '0;
            fill_pa_q      <= '0;
            fill_big_q     <= 1'b0;
            svc_valid_q    <= 1'b0;
            svc_rsp_q      <= '0;
            err_q          <= 1'b0;
            err_va_q       <= '0;
        end else begin
            for (int unsigned i = 0; i < N_ENTRIES; i++)
                entry_q[i] <= entry_d[i];
            walk_req_en_q  <= walk_req_en_d;
            walk_req_va_q  <= walk_req_va_d;
            walk_req_tag_q <= walk_req_tag_d;
            walk_req_idx_q <= walk_req_idx_d;
            fill_en_q      <= fill_en_d;
            fill_va_q      <= fill_va_d;
            fill_pa_q      <= fill_pa_d;
            fill_big_q     <= fill_big_d;
            svc_valid_q    <= svc_valid_d;
            svc_rsp_q      <= svc_rsp_d;
            err_q          <= err_d;
            err_va_q       <= err_va_d;
        end
    end

    always_comb begin
        missRdy = |free_vec;
        numBusy = '0;
        for (int unsigned i = 0; i < N_ENTRIES; i++)
            if (entry_q[i].state != VTP_MISS_FREE)
                numBusy = numBusy + CNT_W'(1);
    end

    assign walkReqEn     = walk_req_en_q;
    assign walkReqVA     = walk_req_va_q;
    assign walkReqTag    = walk_req_tag_q;
    assign walkReqMeta   = META_W'(walk_req_idx_q);
    assign fillEn        = fill_en_q;
    assign fillVA        = fill_va_q;
    assign fillPA        = fill_pa_q;
    assign fillBigPage   = fill_big_q;
    assign svcRspValid   = svc_valid_q;
    assign svcRsp        = svc_rsp_q;
    assign errNotPresent = err_q;
    assign errVA         = err_va_q;

    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (miss_acc)
                assert (!tag_dup);
            if (walkRspEn)
                assert (entry_q[rsp_idx].state == VTP_MISS_WALK);
        end
    end

endmodule

// File: tb/tb_cci_mpf_svc_vtp_miss_tracker.sv
// Directed bench for the VTP miss tracker: scoreboard queues hold expected
// walk requests, TLB fills and lookup responses, popped as the DUT emits them.
module tb_cci_mpf_svc_vtp_miss_tracker;
    import cci_mpf_svc_vtp_miss_tracker_pkg::*;

    typedef struct packed {
        t_tlb_4kb_va_page_idx           va;
        t_cci_mpf_shim_vtp_req_tag      tag;
        t_cci_mpf_shim_vtp_pt_walk_meta meta;
    } walk_t;

    typedef struct packed {
        t_tlb_4kb_va_page_idx va;
        t_tlb_4kb_pa_page_idx pa;
        logic                 big;
    } fill_t;

    logic                           clk = 1'b0;
    logic                           reset_n;
    logic                           missEn;
    t_tlb_4kb_va_page_idx           missVA;
    t_cci_mpf_shim_vtp_req_tag      missTag;
    logic                           missRdy;
    logic                           walkReqEn;
    t_tlb_4kb_va_page_idx           walkReqVA;
    t_cci_mpf_shim_vtp_req_tag      walkReqTag;
    t_cci_mpf_shim_vtp_pt_walk_meta walkReqMeta;
    logic                           walkReqRdy;
    logic                           walkRspEn;
    t_tlb_4kb_va_page_idx           walkRspVA;
    t_tlb_4kb_pa_page_idx           walkRspPA;
    t_cci_mpf_shim_vtp_pt_walk_meta walkRspMeta;
    t_cci_mpf_shim_vtp_req_tag      walkRspTag;
    logic                           walkRspIsBigPage;
    logic                           walkRspNotPresent;
    logic                           fillEn;
    t_tlb_4kb_va_page_idx           fillVA;
    t_tlb_4kb_pa_page_idx           fillPA;
    logic                           fillBigPage;
    logic                           svcRspValid;
    t_cci_mpf_shim_vtp_lookup_rsp   svcRsp;
    logic                           errNotPresent;
    t_tlb_4kb_va_page_idx           errVA;
    logic [2:0]                     numBusy;

    int checks = 0;
    int errors = 0;

    walk_t                          exp_walk[$];
    fill_t                          exp_fill[$];
    t_cci_mpf_shim_vtp_lookup_rsp   exp_svc[$];
    t_cci_mpf_shim_vtp_pt_walk_meta seen_meta[$];
    t_tlb_4kb_va_page_idx           seen_va[$];

    walk_t                          w_exp;
    fill_t                          f_exp;
    t_cci_mpf_shim_vtp_lookup_rsp   s_exp;

    cci_mpf_svc_vtp_miss_tracker #(.N_ENTRIES(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .missEn(missEn), .missVA(missVA), .missTag(missTag), .missRdy(missRdy),
        .walkReqEn(walkReqEn), .walkReqVA(walkReqVA), .walkReqTag(walkReqTag),
        .walkReqMeta(walkReqMeta), .walkReqRdy(walkReqRdy),
        .walkRspEn(walkRspEn), .walkRspVA(walkRspVA), .walkRspPA(walkRspPA),
        .walkRspMeta(walkRspMeta), .walkRspTag(walkRspTag),
        .walkRspIsBigPage(walkRspIsBigPage), .walkRspNotPresent(walkRspNotPresent),
        .fillEn(fillEn), .fillVA(fillVA), .fillPA(fillPA), .fillBigPage(fillBigPage),
        .svcRspValid(svcRspValid), .svcRsp(svcRsp),
        .errNotPresent(errNotPresent), .errVA(errVA), .numBusy(numBusy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_miss(input t_tlb_4kb_va_page_idx va, input t_cci_mpf_shim_vtp_req_tag tag);
        missEn  = 1'b1;
        missVA  = va;
        missTag = tag;
        step();
        missEn  = 1'b0;
    endtask

    task automatic wait_walk(output t_cci_mpf_shim_vtp_pt_walk_meta m,
                             output t_tlb_4kb_va_page_idx v);
        int unsigned n = 0;
        m = '0;
        v = '0;
        while (seen_meta.size() == 0 && n < 50) begin
            step();
            n++;
        end
        check("walk_req_seen", seen_meta.size() != 0, 1);
        if (seen_meta.size() != 0) begin
            m = seen_meta.pop_front();
            v = seen_va.pop_front();
        end
    endtask

    task automatic respond(input t_cci_mpf_shim_vtp_pt_walk_meta m, input t_tlb_4kb_va_page_idx v,
                           input t_tlb_4kb_pa_page_idx p, input logic big, input logic np);
        if (!np)
            exp_fill.push_back('{va: v, pa: p, big: big});
        walkRspEn         = 1'b1;
        walkRspMeta       = m;
        walkRspVA         = v;
        walkRspPA         = p;
        walkRspIsBigPage  = big;
        walkRspNotPresent = np;
        walkRspTag        = '0;
        step();
        walkRspEn         = 1'b0;
        walkRspNotPresent = 1'b0;
        check("fill_at_t_plus_1", fillEn, !np);
    endtask

    always @(negedge clk) begin
        if (walkReqEn === 1'b1 && walkReqRdy === 1'b1) begin
            check("walk_expected", exp_walk.size() != 0, 1);
            if (exp_walk.size() != 0) begin
                w_exp = exp_walk.pop_front();
                check("walk_va", walkReqVA, w_exp.va);
                check("walk_tag", walkReqTag, w_exp.tag);
                check("walk_meta", walkReqMeta, w_exp.meta);
            end
            seen_meta.push_back(walkReqMeta);
            seen_va.push_back(walkReqVA);
        end
        if (fillEn === 1'b1) begin
            check("fill_expected", exp_fill.size() != 0, 1);
            if (exp_fill.size() != 0) begin
                f_exp = exp_fill.pop_front();
                check("fill_va", fillVA, f_exp.va);
                check("fill_pa", fillPA, f_exp.pa);
                check("fill_big", fillBigPage, f_exp.big);
            end
        end
        if (svcRspValid === 1'b1) begin
            check("svc_expected", exp_svc.size() != 0, 1);
            if (exp_svc.size() != 0) begin
                s_exp = exp_svc.pop_front();
                check("svc_rsp", svcRsp, s_exp);
            end
        end
    end

    initial begin
        t_cci_mpf_shim_vtp_pt_walk_meta m;
        t_tlb_4kb_va_page_idx           v;
        t_tlb_4kb_va_page_idx           full_va [4];

        reset_n = 1'b0; missEn = 1'b0; missVA = '0; missTag = '0; walkReqRdy = 1'b0;
        walkRspEn = 1'b0; walkRspVA = '0; walkRspPA = '0; walkRspMeta = '0; walkRspTag = '0;
        walkRspIsBigPage = 1'b0; walkRspNotPresent = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_missRdy", missRdy, 1);
        check("rst_walkReqEn", walkReqEn, 0);
        check("rst_fillEn", fillEn, 0);
        check("rst_svcRspValid", svcRspValid, 0);
        check("rst_err", errNotPresent, 0);
        check("rst_numBusy", numBusy, 0);
        reset_n = 1'b1;
        step();

        // Single miss, walker stalls for two cycles first.
        exp_walk.push_back('{va: 36'h100, tag: 4'd3, meta: 8'd0});
        do_miss(36'h100, 4'd3);
        check("alloc_walkReqEn", walkReqEn, 1);
        check("alloc_numBusy", numBusy, 1);
        step();
        step();
        check("hold_walkReqEn", walkReqEn, 1);
        check("hold_walkReqVA", walkReqVA, 36'h100);
        walkReqRdy = 1'b1;
        wait_walk(m, v);
        exp_svc.push_back('{pagePA: 28'h2000, tag: 4'd3, isBigPage: 1'b0});
        respond(m, v, 28'h2000, 1'b0, 1'b0);
        check("single_no_svc_t1", svcRspValid, 0);
        step();
        check("single_svc_t2", svcRspValid, 1);
        step();
        check("single_numBusy", numBusy, 0);

        // Merge three tags onto one page.
        exp_walk.push_back('{va: 36'h40, tag: 4'd1, meta: 8'd0});
        do_miss(36'h40, 4'd1);
        do_miss(36'h40, 4'd5);
        do_miss(36'h40, 4'd9);
        wait_walk(m, v);
        step();
        step();
        check("merge_one_walk", seen_meta.size(), 0);
        check("merge_numBusy", numBusy, 1);
        exp_svc.push_back('{pagePA: 28'h5a5, tag: 4'd1, isBigPage: 1'b0});
        exp_svc.push_back('{pagePA: 28'h5a5, tag: 4'd5, isBigPage: 1'b0});
        exp_svc.push_back('{pagePA: 28'h5a5, tag: 4'd9, isBigPage: 1'b0});
        respond(m, v, 28'h5a5, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("merge_svc_consec", svcRspValid, 1);
        end
        step();
        check("merge_svc_done", svcRspValid, 0);
        check("merge_numBusy_0", numBusy, 0);

        // Fill the table, then answer out of order.
        for (int i = 0; i < 4; i++) begin
            exp_walk.push_back('{va: 36'h200 + 36'(i), tag: 4'(2 * i), meta: 8'(i)});
            missEn  = 1'b1;
            missVA  = 36'h200 + 36'(i);
            missTag = 4'(2 * i);
            step();
        end
        missVA  = 36'h201;
        missTag = 4'd13;
        check("full_missRdy", missRdy, 0);
        check("full_numBusy", numBusy, 4);
        step();
        missEn = 1'b0;
        check("full_blocked_merge", numBusy, 4);
        for (int i = 0; i < 4; i++) begin
            wait_walk(m, v);
            full_va[i] = v;
        end
        exp_svc.push_back('{pagePA: 28'h3002, tag: 4'd4, isBigPage: 1'b0});
        respond(8'd2, full_va[2], 28'h3002, 1'b0, 1'b0);
        check("full_rdy_low_t1", missRdy, 0);
        step();
        check("full_rdy_back", missRdy, 1);
        check("full_numBusy_3", numBusy, 3);
        exp_svc.push_back('{pagePA: 28'h3000, tag: 4'd0, isBigPage: 1'b1});
        respond(8'd0, full_va[0], 28'h3000, 1'b1, 1'b0);
        step();
        step();
        exp_svc.push_back('{pagePA: 28'h3003, tag: 4'd6, isBigPage: 1'b0});
        respond(8'd3, full_va[3], 28'h3003, 1'b0, 1'b0);
        step();
        step();
        exp_svc.push_back('{pagePA: 28'h3001, tag: 4'd2, isBigPage: 1'b0});
        respond(8'd1, full_va[1], 28'h3001, 1'b0, 1'b0);
        step();
        step();
        check("ooo_numBusy_0", numBusy, 0);

        // Not-present walk; a second fault must not overwrite errVA.
        exp_walk.push_back('{va: 36'h7, tag: 4'd7, meta: 8'd0});
        do_miss(36'h7, 4'd7);
        wait_walk(m, v);
        respond(m, v, 28'h0, 1'b0, 1'b1);
        check("np_numBusy", numBusy, 0);
        step();
        check("np_no_svc", svcRspValid, 0);
        check("np_err", errNotPresent, 1);
        check("np_errVA", errVA, 36'h7);
        exp_walk.push_back('{va: 36'h9, tag: 4'd8, meta: 8'd0});
        do_miss(36'h9, 4'd8);
        wait_walk(m, v);
        respond(m, v, 28'h0, 1'b0, 1'b1);
        step();
        check("np_errVA_sticky", errVA, 36'h7);

        // Reset in the middle of a three-tag drain.
        exp_walk.push_back('{va: 36'h55, tag: 4'd10, meta: 8'd0});
        do_miss(36'h55, 4'd10);
        do_miss(36'h55, 4'd11);
        do_miss(36'h55, 4'd12);
        wait_walk(m, v);
        exp_svc.push_back('{pagePA: 28'h77, tag: 4'd10, isBigPage: 1'b0});
        respond(m, v, 28'h77, 1'b0, 1'b0);
        step();
        check("rstmid_first_svc", svcRspValid, 1);
        reset_n = 1'b0;
        step();
        check("rstmid_no_svc", svcRspValid, 0);
        check("rstmid_numBusy", numBusy, 0);
        check("rstmid_missRdy", missRdy, 1);
        check("rstmid_err_clear", errNotPresent, 0);
        reset_n = 1'b1;
        step();
        step();

        check("end_walk_q", exp_walk.size(), 0);
        check("end_fill_q", exp_fill.size(), 0);
        check("end_svc_q", exp_svc.size(), 0);
        check("end_seen_q", seen_meta.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
